fetch_queue: RTL and testbench

//  Parametrised IF/ID decoupling queue that replaces the single IF/ID register.

---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_mem.sv | 39 +++
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg
//   Constants shared by the IF/ID fetch queue and its storage array:
//   the bubble PCs used after reset and after an exception, the default
//   exception code width, the "no exception" code and the nop encoding
//   that is presented to ID while the queue is empty.
package fetch_queue_pkg;

  localparam int unsigned FQ_EXC_W      = 5;
  localparam logic [31:0] FQ_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] FQ_HANDLER_PC = 32'h0000_4180;
  localparam int unsigned FQ_EXC_NONE   = 0;
  localparam int unsigned FQ_NOP_INSTR  = 0;

  // Occupancy counter width; it has to hold the value DEPTH itself
  function automatic int unsigned fqCountWidth(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// fetch_queue_mem
//   DEPTH x WIDTH register array holding the packed queue entries.
//   One synchronous write port and one asynchronous read port, so the
//   head entry is visible to ID in the same cycle the read pointer moves.
// Ports
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address (queue write pointer)
//   wdata_i  in   packed entry {instr, pc, exc, bd}
//   raddr_i  in   read address (queue read pointer)
//   rdata_o  out  packed entry stored at raddr_i
module fetch_queue_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 70,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage needs no reset: occupancy lives in the top level, so stale
  // entries are never presented to ID.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue
//   IF/ID decoupling queue. IF pushes {Instr, PC, ExcCode, BDIn} with a
//   valid/ready handshake, ID pops the head. When empty, ID sees a nop
//   bubble whose PC is the last popped PC (or RESET_PC / HANDLER_PC after
//   reset / exception). Priority each cycle: reset > Req > Flush > push/pop.
// Ports
//   clk, reset            clock, synchronous active-high reset
//   Req                   exception flush, bubble PC becomes HANDLER_PC
//   Flush                 redirect flush, discards all entries
//   ValidF/ReadyF         IF handshake; ReadyF = not full
//   InstrF/PCF/ExcCodeF/BDInF  entry offered by IF
//   ValidD/ReadyD         ID handshake; ValidD = not empty
//   InstrD/PCD/ExcCodeD/BDInD  head entry or bubble
//   Count                 current occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned       DEPTH      = 2,
  parameter int unsigned       INSTR_W    = 32,
  parameter int unsigned       PC_W       = 32,
  parameter int unsigned       EXC_W      = FQ_EXC_W,
  parameter logic [PC_W-1:0]   RESET_PC   = PC_W'(FQ_RESET_PC),
  parameter logic [PC_W-1:0]   HANDLER_PC = PC_W'(FQ_HANDLER_PC),
  localparam int unsigned      CNT_W      = fqCountWidth(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Req,
  input  logic               Flush,
  input  logic               ValidF,
  output logic               ReadyF,
  input  logic [INSTR_W-1:0] InstrF,
  input  logic [PC_W-1:0]    PCF,
  input  logic [EXC_W-1:0]   ExcCodeF,
  input  logic               BDInF,
  output logic               ValidD,
  input  logic               ReadyD,
  output logic [INSTR_W-1:0] InstrD,
  output logic [PC_W-1:0]    PCD,
  output logic [EXC_W-1:0]   ExcCodeD,
  output logic               BDInD,
  output logic [CNT_W-1:0]   Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned ENT_W = INSTR_W + PC_W + EXC_W + 1;

  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PC_W-1:0]    bubblePc_q, bubblePc_d;
  logic               push, pop, memWe;
  logic [ENT_W-1:0]   headEntry;
  logic [INSTR_W-1:0] headInstr;
  logic [PC_W-1:0]    headPc;
  logic [EXC_W-1:0]   headExc;
  logic               headBd;

  // Handshake flags come only from the registered count
  assign ValidD = (count_q != '0);
  assign ReadyF = (count_q != CNT_W'(DEPTH));
  assign push   = ValidF & ReadyF;
  assign pop    = ValidD & ReadyD;
  assign memWe  = push & ~Req & ~Flush & ~reset;

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (memWe),
    .waddr_i (wrPtr_q),
    .wdata_i ({InstrF, PCF, ExcCodeF, BDInF}),
    .raddr_i (rdPtr_q),
    .rdata_o (headEntry)
  );

  assign {headInstr, headPc, headExc, headBd} = headEntry;

  // Next-state logic; flushes drop any same-cycle push/pop.
  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    bubblePc_d = bubblePc_q;
    if (Req) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      bubblePc_d = HANDLER_PC;
    end else if (Flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_d    = rdPtr_q + 1'b1;
        bubblePc_d = headPc;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      bubblePc_q <= RESET_PC;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      bubblePc_q <= bubblePc_d;
    end
  end

  // Bubble mux: an empty queue shows a nop at the last known PC
  assign InstrD   = ValidD ? headInstr : INSTR_W'(FQ_NOP_INSTR);
  assign PCD      = ValidD ? headPc    : bubblePc_q;
  assign ExcCodeD = ValidD ? headExc   : EXC_W'(FQ_EXC_NONE);
  assign BDInD    = ValidD ? headBd    : 1'b0;
  assign Count    = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=2). A scoreboard queue mirrors
//   the expected queue contents plus the expected bubble PC; every cycle
//   the DUT's D-side outputs, ReadyF and Count are compared against it.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } entry_t;

  logic        clk = 1'b0;
  logic        reset, Req, Flush, ValidF, ReadyF, BDInF, ValidD, ReadyD, BDInD;
  logic [31:0] InstrF, PCF, InstrD, PCD;
  logic [4:0]  ExcCodeF, ExcCodeD;
  logic [1:0]  Count;

  entry_t      sb[$];
  logic [31:0] mBubble;
  int          errors = 0;
  int          checks = 0;
  string       stepName;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .Req      (Req),
    .Flush    (Flush),
    .ValidF   (ValidF),
    .ReadyF   (ReadyF),
    .InstrF   (InstrF),
    .PCF      (PCF),
    .ExcCodeF (ExcCodeF),
    .BDInF    (BDInF),
    .ValidD   (ValidD),
    .ReadyD   (ReadyD),
    .InstrD   (InstrD),
    .PCD      (PCD),
    .ExcCodeD (ExcCodeD),
    .BDInD    (BDInD),
    .Count    (Count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s/%s observed=%h expected=%h", stepName, tag, obs, exp);
    end
  endtask

  // Compare all observable outputs against the scoreboard head / bubble
  task automatic checkOutput();
    entry_t head;
    bit     nonEmpty;
    nonEmpty = (sb.size() != 0);
    head     = nonEmpty ? sb[0] : '0;
    check("ValidD", {31'd0, ValidD}, {31'd0, nonEmpty});
    check("ReadyF", {31'd0, ReadyF}, {31'd0, sb.size() != DEPTH});
    check("Count", {30'd0, Count}, sb.size());
    check("InstrD", InstrD, nonEmpty ? head.instr : 32'd0);
    check("PCD", PCD, nonEmpty ? head.pc : mBubble);
    check("ExcCodeD", {27'd0, ExcCodeD}, nonEmpty ? {27'd0, head.exc} : 32'd0);
    check("BDInD", {31'd0, BDInD}, nonEmpty ? {31'd0, head.bd} : 32'd0);
  endtask

  // Drive one cycle of inputs (called at a negedge), update the model at
  // the posedge, then check at the following negedge.
  task automatic applyStimulus(input logic rst, input logic req, input logic flush,
                               input logic vf, input logic [31:0] instr,
                               input logic [31:0] pc, input logic [4:0] exc,
                               input logic bd, input logic rd);
    bit mPush, mPop;
    reset = rst; Req = req; Flush = flush; ValidF = vf;
    InstrF = instr; PCF = pc; ExcCodeF = exc; BDInF = bd; ReadyD = rd;
    mPush = vf && (sb.size() < DEPTH);
    mPop  = rd && (sb.size() > 0);
    @(posedge clk);
    if (rst) begin
      sb.delete();
      mBubble = 32'h0000_3000;
    end else if (req) begin
      sb.delete();
      mBubble = 32'h0000_4180;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (mPop) begin
        mBubble = sb[0].pc;
        void'(sb.pop_front());
      end
      if (mPush) begin
        sb.push_back('{instr: instr, pc: pc, exc: exc, bd: bd});
      end
    end
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; Flush = 1'b0; ValidF = 1'b0; ReadyD = 1'b0;
    InstrF = '0; PCF = '0; ExcCodeF = '0; BDInF = 1'b0;
    mBubble = 32'h0000_3000;
    @(negedge clk);

    // 1: reset then idle
    stepName = "reset";
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    stepName = "idle";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 2: fill with ID stalled, third push held, then drain in order
    stepName = "fill";
    applyStimulus(0, 0, 0, 1, 32'h2401_0001, 32'h0000_3000, 5'd0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h2402_0002, 32'h0000_3004, 5'd0, 1, 0);
    stepName = "held";
    applyStimulus(0, 0, 0, 1, 32'h2403_0003, 32'h0000_3008, 5'd4, 0, 0);
    stepName = "popFull";
    applyStimulus(0, 0, 0, 1, 32'h2403_0003, 32'h0000_3008, 5'd4, 0, 1);
    stepName = "popPush";
    applyStimulus(0, 0, 0, 1, 32'h2403_0003, 32'h0000_3008, 5'd4, 0, 1);
    stepName = "drain";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 3: steady stream, exercises pointer wrap
    stepName = "stream";
    for (int i = 0; i < 3 * DEPTH + 3; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h1000_0000 + i, 32'h0000_5000 + 4 * i,
                    5'(i), i[0], 1);
    end
    stepName = "streamDrain";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 4: full queue flushed with a simultaneous push
    stepName = "flushFill";
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0001, 32'h0000_6000, 5'd0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hAAAA_0002, 32'h0000_6004, 5'd0, 0, 0);
    stepName = "flush";
    applyStimulus(0, 0, 1, 1, 32'hAAAA_0003, 32'h0000_6008, 5'd0, 0, 1);

    // 5: Req together with Flush, push and pop
    stepName = "reqFill";
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0001, 32'h0000_7000, 5'd2, 1, 0);
    applyStimulus(0, 0, 0, 1, 32'hBBBB_0002, 32'h0000_7004, 5'd0, 0, 0);
    stepName = "req";
    applyStimulus(0, 1, 1, 1, 32'hBBBB_0003, 32'h0000_7008, 5'd0, 0, 1);
    stepName = "handlerPush";
    applyStimulus(0, 0, 0, 1, 32'h401A_6800, 32'h0000_4180, 5'd0, 0, 0);
    stepName = "handlerPop";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // 6: reset beats Req while full
    stepName = "rstFill";
    applyStimulus(0, 0, 0, 1, 32'hCCCC_0001, 32'h0000_8000, 5'd0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hCCCC_0002, 32'h0000_8004, 5'd0, 0, 0);
    stepName = "rstReq";
    applyStimulus(1, 1, 0, 1, 32'hCCCC_0003, 32'h0000_8008, 5'd0, 0, 1);
    stepName = "postRst";
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
